tcam_pe: RTL and testbench
==========================

Name: tcam_pe

Overview:
- Parametrised ternary CAM: DEPTH = 2^ADDR_W entries of DATA_W bits, each with a per-bit care mask and a valid bit.
- Driven through a single command port (write, invalidate, search, flush) with a ready/valid handshake.
- Searches run through a 2-stage pipeline and return the raw match vector, a lowest-index priority-encoded hit, and a multi-hit flag.
- Sits as the lookup engine behind classifier and route-table logic in the lab designs.

Parameters:
- DATA_W, 8, key/entry width in bits.
- ADDR_W, 3, entry address width; DEPTH = 1 << ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present this cycle.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  00 WRITE, 01 INVALIDATE, 10 SEARCH, 11 FLUSH.
- cmd_addr  in  ADDR_W  entry index for WRITE/INVALIDATE.
- cmd_data  in  DATA_W  entry data (WRITE) or search key (SEARCH).
- cmd_mask  in  DATA_W  WRITE: entry care mask, 1 = compare, 0 = don't care. SEARCH: key mask, 0 = ignore the bit for every entry.
- rsp_valid  out  1  one-cycle pulse, search result valid.
- rsp_match  out  DEPTH  per-entry match vector.
- rsp_hit  out  1  at least one entry matched.
- rsp_index  out  ADDR_W  lowest matching index; 0 when rsp_hit = 0.
- rsp_multi  out  1  two or more entries matched.
- entry_valid  out  DEPTH  current valid bits.
- busy  out  1  flush in progress.

Behaviour:
- Reset (synchronous, highest priority):
  - All entry_valid, data and mask bits clear to 0; FSM goes to IDLE.
  - Both pipeline stages are squashed, so no rsp_valid follows reset.
  - Output values during and after reset: cmd_ready = 1, rsp_valid = 0, rsp_match = 0, rsp_hit = 0, rsp_index = 0, rsp_multi = 0, busy = 0.
- Handshake: a command is accepted on a rising edge where cmd_valid & cmd_ready; one command per cycle; cmd_ready = (state == IDLE).
- Entry i matches when entry_valid[i] = 1 and ((entry_data[i] ^ key) & entry_mask[i] & key_mask) == 0.
  - All-zero combined mask on a valid entry: always a match.
- WRITE: at the accept edge, data, mask and valid[addr] = 1 are updated. An overwrite replaces the previous contents.
- INVALIDATE: at the accept edge, valid[addr] = 0; data and mask are left untouched.
- SEARCH timing:
  - Accepted in cycle T; stage 1 registers the match vector at the end of T, using table state before any edge-T update.
  - Stage 2 registers the encoded outputs at the end of T+1; rsp_valid is high in cycle T+2 only.
  - Fully pipelined: back-to-back searches give back-to-back responses.
- Ordering:
  - WRITE at T then SEARCH at T+1: the search sees the write.
  - SEARCH at T then WRITE at T+1: the search does not see the write.
- Response hold: rsp_match, rsp_hit, rsp_index and rsp_multi hold their last values when rsp_valid = 0.
- FSM states: IDLE, FLUSH.
  - IDLE --FLUSH accepted--> FLUSH; the flush counter loads 0.
  - In FLUSH, each cycle clears valid[counter] and increments the counter. When counter == DEPTH-1, that entry is cleared and the FSM returns to IDLE.
  - A flush lasts DEPTH cycles with busy = 1 and cmd_ready = 0. The counter is ADDR_W bits and must not wrap into a second pass.
- Flush interaction: searches accepted before the FLUSH still drain through the pipeline with their pre-flush results.
- Reset during FLUSH: immediate return to IDLE with all entries invalid.
- Priority encoder: scans index 0 upward; rsp_multi = popcount(match) >= 2, computed without a full adder tree (hit OR-reduction plus a "second hit" chain).
- Undefined cases: none; all four opcodes are defined, and addresses are full-range by construction.

Decomposition:
- Package tcam_pkg:
  - opcode constants OP_WRITE, OP_INVALIDATE, OP_SEARCH, OP_FLUSH;
  - state encodings ST_IDLE, ST_FLUSH.
- Sub-module tcam_prio_enc (parameters ADDR_W):
  - input: DEPTH-bit vector;
  - outputs: hit, index, multi;
  - combinational; instantiated in stage 2.
- Storage, match-vector generation and the FSM stay in tcam_pe.

Test Plan:
- Reset, then SEARCH key 8'hAA, mask 8'hFF -> rsp_valid in cycle T+2 with match = 0, hit = 0, index = 0, multi = 0; entry_valid = 0.
- WRITE addr 5 data 8'hA0 mask 8'hF0; SEARCH 8'hA7 mask 8'hFF -> match = 8'b0010_0000, hit = 1, index = 5, multi = 0.
- Also WRITE addr 2 data 8'h00 mask 8'h00; SEARCH 8'hA7 -> match = 8'b0010_0100, index = 2, multi = 1. INVALIDATE 2, then SEARCH -> index = 5, multi = 0.
- Key mask: entry 1 data 8'h3C mask 8'hFF; SEARCH key 8'h30 keymask 8'hF0 -> hit, index = 1. Same key with keymask 8'hFF -> no hit on entry 1.
- Ordering: WRITE addr 3 then SEARCH on the next cycle -> entry 3 matches. SEARCH, then WRITE addr 4 on the next cycle with matching data -> bit 4 of that response is 0.
- FLUSH with 3 valid entries and a SEARCH accepted one cycle earlier:
  - the search responds with its pre-flush hits;
  - cmd_ready = 0 and busy = 1 for exactly 8 cycles, then entry_valid = 0.
  - Repeat with reset asserted at flush cycle 3 -> IDLE on the next cycle, entry_valid = 0.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared opcodes and FSM encodings for the ternary CAM lookup engine.
package tcam_pkg;

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_INVALIDATE = 2'b01;
  localparam logic [1:0] OP_SEARCH     = 2'b10;
  localparam logic [1:0] OP_FLUSH      = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder with hit and multi-hit flags over a match vector.
module tcam_prio_enc #(
  parameter int ADDR_W = 3,
  localparam int DEPTH = 1 << ADDR_W
) (
  input  logic [DEPTH-1:0]  match_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] index_o,
  output logic              multi_o
);

  logic seen;

  assign hit_o = |match_i;

  // Scan from the top down so the last assignment wins for the lowest index;
  // multi rides a "seen one already" chain instead of a popcount.
  always_comb begin
    index_o = '0;
    multi_o = 1'b0;
    seen    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_i[i]) index_o = ADDR_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      multi_o = multi_o | (seen & match_i[i]);
      seen    = seen | match_i[i];
    end
  end

endmodule

// File: rtl/tcam_pe.sv
// Ternary CAM: per-bit care masks, single command port, 2-stage search pipeline.
module tcam_pe
  import tcam_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  localparam int DEPTH = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [DEPTH-1:0]  rsp_match,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_index,
  output logic              rsp_multi,
  output logic [DEPTH-1:0]  entry_valid,
  output logic              busy
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DATA_W-1:0] mask_q [DEPTH];
  logic [DATA_W-1:0] mask_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              accept, srch;
  logic [DEPTH-1:0]  match;
  logic [2:1]        vld_pipe_q;
  logic [DEPTH-1:0]  s1_match_q;

  logic              enc_hit, enc_multi;
  logic [ADDR_W-1:0] enc_index;
  logic [DEPTH-1:0]  rsp_match_q;
  logic              rsp_hit_q, rsp_multi_q;
  logic [ADDR_W-1:0] rsp_index_q;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_FLUSH);
  assign accept      = cmd_valid & cmd_ready;
  assign srch        = accept & (cmd_op == OP_SEARCH);
  assign entry_valid = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_WRITE: begin
              data_d[cmd_addr]  = cmd_data;
              mask_d[cmd_addr]  = cmd_mask;
              valid_d[cmd_addr] = 1'b1;
            end
            OP_INVALIDATE: valid_d[cmd_addr] = 1'b0;
            OP_FLUSH: begin
              state_d = ST_FLUSH;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        valid_d[cnt_q] = 1'b0;
        // Counter parks on the last entry so it never starts a second pass.
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  // Match uses pre-edge table state, so a same-cycle write is not visible.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = valid_q[i] & ~|((data_q[i] ^ cmd_data) & mask_q[i] & cmd_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_match_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], srch};
      if (srch) s1_match_q <= match;
    end
  end

  tcam_prio_enc #(.ADDR_W(ADDR_W)) u_enc (
    .match_i (s1_match_q),
    .hit_o   (enc_hit),
    .index_o (enc_index),
    .multi_o (enc_multi)
  );

  // Response registers only load on a valid stage-1 slot and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_match_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_multi_q <= 1'b0;
    end else if (vld_pipe_q[1]) begin
      rsp_match_q <= s1_match_q;
      rsp_hit_q   <= enc_hit;
      rsp_index_q <= enc_index;
      rsp_multi_q <= enc_multi;
    end
  end

  assign rsp_valid = vld_pipe_q[2];
  assign rsp_match = rsp_match_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_index = rsp_index_q;
  assign rsp_multi = rsp_multi_q;

endmodule

// File: tb/tb_tcam_pe.sv
// Bench for tcam_pe: table-driven command stream, response scoreboard, flush/reset sequences.
module tb_tcam_pe;
  import tcam_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data, cmd_mask;
  logic       rsp_valid;
  logic [7:0] rsp_match;
  logic       rsp_hit;
  logic [2:0] rsp_index;
  logic       rsp_multi;
  logic [7:0] entry_valid;
  logic       busy;

  tcam_pe #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_mask    (cmd_mask),
    .rsp_valid   (rsp_valid),
    .rsp_match   (rsp_match),
    .rsp_hit     (rsp_hit),
    .rsp_index   (rsp_index),
    .rsp_multi   (rsp_multi),
    .entry_valid (entry_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] m;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[24];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [2:0] low_idx(logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Response monitor: every rsp_valid pulse must match the oldest pending search.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no pending search (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_match", rsp_match, e.m);
        chk("rsp_hit", rsp_hit, |e.m);
        chk("rsp_index", rsp_index, low_idx(e.m));
        chk("rsp_multi", rsp_multi, $countones(e.m) >= 2);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                       input logic [7:0] m, input logic [7:0] em);
    @(negedge clk);
    chk("ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    if (op == OP_SEARCH) sbq.push_back('{em, cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  int nb;

  initial begin
    vecs[0]  = '{OP_SEARCH,     3'd0, 8'hAA, 8'hFF, 8'h00};
    vecs[1]  = '{OP_WRITE,      3'd5, 8'hA0, 8'hF0, 8'h00};
    vecs[2]  = '{OP_SEARCH,     3'd0, 8'hA7, 8'hFF, 8'b0010_0000};
    vecs[3]  = '{OP_WRITE,      3'd2, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{OP_SEARCH,     3'd0, 8'hA7, 8'hFF, 8'b0010_0100};
    vecs[5]  = '{OP_INVALIDATE, 3'd2, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{OP_SEARCH,     3'd0, 8'hA7, 8'hFF, 8'b0010_0000};
    vecs[7]  = '{OP_WRITE,      3'd1, 8'h3C, 8'hFF, 8'h00};
    vecs[8]  = '{OP_SEARCH,     3'd0, 8'h30, 8'hF0, 8'b0000_0010};
    vecs[9]  = '{OP_SEARCH,     3'd0, 8'h30, 8'hFF, 8'b0000_0000};
    vecs[10] = '{OP_WRITE,      3'd3, 8'h55, 8'hFF, 8'h00};
    vecs[11] = '{OP_SEARCH,     3'd0, 8'h55, 8'hFF, 8'b0000_1000};
    vecs[12] = '{OP_SEARCH,     3'd0, 8'h55, 8'hFF, 8'b0000_1000};
    vecs[13] = '{OP_WRITE,      3'd4, 8'h55, 8'hFF, 8'h00};
    vecs[14] = '{OP_SEARCH,     3'd0, 8'h55, 8'h0F, 8'b0011_1000};
    vecs[15] = '{OP_SEARCH,     3'd0, 8'h00, 8'h00, 8'b0011_1010};
    vecs[16] = '{OP_INVALIDATE, 3'd1, 8'h00, 8'h00, 8'h00};
    vecs[17] = '{OP_INVALIDATE, 3'd3, 8'h00, 8'h00, 8'h00};
    vecs[18] = '{OP_INVALIDATE, 3'd4, 8'h00, 8'h00, 8'h00};
    vecs[19] = '{OP_WRITE,      3'd7, 8'hFF, 8'hFF, 8'h00};
    vecs[20] = '{OP_SEARCH,     3'd0, 8'hFF, 8'hFF, 8'b1000_0000};
    vecs[21] = '{OP_WRITE,      3'd7, 8'h00, 8'hFF, 8'h00};
    vecs[22] = '{OP_SEARCH,     3'd0, 8'hFF, 8'hFF, 8'b0000_0000};
    vecs[23] = '{OP_SEARCH,     3'd0, 8'h00, 8'hFF, 8'b1000_0000};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_match", rsp_match, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_index", rsp_index, 0);
    chk("rst_rsp_multi", rsp_multi, 0);
    chk("rst_entry_valid", entry_valid, 0);
    reset = 1'b0;

    // Back-to-back command stream, one per cycle.
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].exp);
    idle(4);
    chk("valid_after_table", entry_valid, 8'hA0);
    chk("hold_rsp_valid", rsp_valid, 0);
    chk("hold_rsp_match", rsp_match, 8'h80);
    chk("hold_rsp_index", rsp_index, 7);
    chk("hold_rsp_hit", rsp_hit, 1);

    // Flush one cycle after a search: the search drains with pre-flush hits.
    issue(OP_WRITE, 3'd0, 8'h00, 8'h00, 8'h00);
    issue(OP_SEARCH, 3'd0, 8'h00, 8'hFF, 8'b1000_0001);
    issue(OP_FLUSH, 3'd0, 8'h00, 8'h00, 8'h00);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (busy && !cmd_ready) nb++;
      else break;
    end
    chk("flush_cycles", nb, 8);
    chk("flush_ready_after", cmd_ready, 1);
    chk("flush_valid_after", entry_valid, 0);
    issue(OP_SEARCH, 3'd0, 8'h00, 8'h00, 8'h00);
    idle(4);

    // Reset in the middle of a flush.
    issue(OP_WRITE, 3'd1, 8'hF0, 8'hFF, 8'h00);
    issue(OP_WRITE, 3'd6, 8'h0F, 8'hFF, 8'h00);
    issue(OP_SEARCH, 3'd0, 8'hF0, 8'hFF, 8'b0000_0010);
    idle(3);
    issue(OP_FLUSH, 3'd0, 8'h00, 8'h00, 8'h00);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (busy) nb++;
      if (nb == 3 || !busy) break;
    end
    chk("flush_busy_before_rst", nb, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midflush_rst_busy", busy, 0);
    chk("midflush_rst_ready", cmd_ready, 1);
    chk("midflush_rst_valid", entry_valid, 0);
    chk("midflush_rst_rsp_match", rsp_match, 0);
    chk("midflush_rst_rsp_hit", rsp_hit, 0);
    chk("midflush_rst_rsp_index", rsp_index, 0);
    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
